// File: rtl/fpu_unpack.sv
// Unpacks a single- or double-precision operand into sign, 13-bit exponent, 53-bit significand and class.
// Optional macro FPU_UNPACK_DAZ_EN flushes denormal inputs to signed zero and removes the normalizer.
module fpu_unpack (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_op,
  input  logic        in_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [12:0] out_exp,
  output logic [52:0] out_mant,
  output logic [4:0]  out_class,
  output logic        out_p
);

  localparam logic [1:0] IDLE = 2'd0;
`ifndef FPU_UNPACK_DAZ_EN
  localparam logic [1:0] NORM = 2'd1;
`endif
  localparam logic [1:0] HOLD = 2'd2;

  // Class bits: {snan, qnan, inf, zero, denorm}
  localparam logic [4:0] CLS_SNAN   = 5'b10000;
  localparam logic [4:0] CLS_QNAN   = 5'b01000;
  localparam logic [4:0] CLS_INF    = 5'b00100;
  localparam logic [4:0] CLS_ZERO   = 5'b00010;
  localparam logic [4:0] CLS_DENORM = 5'b00001;

  logic [1:0]  state;
  logic [10:0] dp_e;
  logic [7:0]  sp_e;
  logic        e_zero;
  logic        e_ones;
  logic [51:0] frac;
  logic [12:0] exp_ext;
  logic [12:0] dec_exp;
  logic [52:0] dec_mant;
  logic [4:0]  dec_class;
  logic        dec_norm;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // Field extraction; the SP fraction is left-aligned so both formats share the normalizer.
  always_comb begin
    dp_e      = in_op[62:52];
    sp_e      = in_op[62:55];
    e_zero    = in_p ? (sp_e == 8'd0) : (dp_e == 11'd0);
    e_ones    = in_p ? (&sp_e) : (&dp_e);
    frac      = in_p ? {in_op[54:32], 29'd0} : in_op[51:0];
    exp_ext   = in_p ? {5'd0, sp_e} : {2'd0, dp_e};
    dec_exp   = exp_ext;
    dec_mant  = {1'b1, frac};
    dec_class = 5'd0;
    dec_norm  = 1'b0;
    if (e_ones) begin
      dec_mant = {1'b0, frac};
      if (frac == 52'd0)
        dec_class = CLS_INF;
      else if (frac[51])
        dec_class = CLS_QNAN;
      else
        dec_class = CLS_SNAN;
    end else if (e_zero) begin
      if (frac == 52'd0) begin
        dec_exp   = 13'd0;
        dec_mant  = 53'd0;
        dec_class = CLS_ZERO;
      end else begin
`ifdef FPU_UNPACK_DAZ_EN
        dec_exp   = 13'd0;
        dec_mant  = 53'd0;
        dec_class = CLS_ZERO | CLS_DENORM;
`else
        dec_exp   = 13'd1;
        dec_mant  = {1'b0, frac};
        dec_class = CLS_DENORM;
        dec_norm  = 1'b1;
`endif
      end
    end
  end

`ifndef FPU_UNPACK_DAZ_EN
  logic [1:0] fine_lzc;

  always_comb begin
    if (out_mant[52])
      fine_lzc = 2'd0;
    else if (out_mant[51])
      fine_lzc = 2'd1;
    else if (out_mant[50])
      fine_lzc = 2'd2;
    else
      fine_lzc = 2'd3;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_sign  <= 1'b0;
      out_exp   <= 13'd0;
      out_mant  <= 53'd0;
      out_class <= 5'd0;
      out_p     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_sign  <= in_op[63];
            out_p     <= in_p;
            out_exp   <= dec_exp;
            out_mant  <= dec_mant;
            out_class <= dec_class;
`ifdef FPU_UNPACK_DAZ_EN
            state     <= dec_norm ? IDLE : HOLD;
`else
            state     <= dec_norm ? NORM : HOLD;
`endif
          end
        end
`ifndef FPU_UNPACK_DAZ_EN
        // Nibble-wide coarse shifts, then one fine shift of 0..3 finishes the denormal.
        NORM: begin
          if (out_mant[52:49] == 4'd0) begin
            out_mant <= out_mant << 4;
            out_exp  <= out_exp - 13'd4;
          end else begin
            out_mant <= out_mant << fine_lzc;
            out_exp  <= out_exp - {11'd0, fine_lzc};
            state    <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_unpack.sv
// Scoreboard bench for fpu_unpack: expected results are queued at drive time and compared when out_valid appears.
// Honours FPU_UNPACK_DAZ_EN in its reference model.
module tb_fpu_unpack;

  typedef struct {
    logic        sign;
    logic [12:0] exp;
    logic [52:0] mant;
    logic [4:0]  cls;
    logic        p;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_op = 64'd0;
  logic        in_p = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [12:0] out_exp;
  logic [52:0] out_mant;
  logic [4:0]  out_class;
  logic        out_p;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  fpu_unpack dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_p(in_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_class(out_class), .out_p(out_p)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Reference model: bit-by-bit normalization, latency counted in edges including acceptance.
  function automatic exp_t model(input logic [63:0] op, input logic p);
    exp_t        r;
    logic [51:0] frac;
    logic        ez, eo;
    logic [12:0] ee;
    int          s;
    r.sign = op[63];
    r.p    = p;
    r.lat  = 1;
    r.cls  = 5'd0;
    if (p) begin
      ez = (op[62:55] == 8'd0);
      eo = (op[62:55] == 8'hFF);
      ee = {5'd0, op[62:55]};
      frac = {op[54:32], 29'd0};
    end else begin
      ez = (op[62:52] == 11'd0);
      eo = (op[62:52] == 11'h7FF);
      ee = {2'd0, op[62:52]};
      frac = op[51:0];
    end
    r.exp  = ee;
    r.mant = {1'b1, frac};
    if (eo) begin
      r.mant = {1'b0, frac};
      r.cls  = (frac == 0) ? 5'b00100 : (frac[51] ? 5'b01000 : 5'b10000);
    end else if (ez && frac == 0) begin
      r.exp  = 13'd0;
      r.mant = 53'd0;
      r.cls  = 5'b00010;
    end else if (ez) begin
`ifdef FPU_UNPACK_DAZ_EN
      r.exp  = 13'd0;
      r.mant = 53'd0;
      r.cls  = 5'b00011;
`else
      r.mant = {1'b0, frac};
      s = 0;
      while (r.mant[52] == 1'b0) begin
        r.mant = r.mant << 1;
        s++;
      end
      r.exp = 13'd1 - 13'(s);
      r.cls = 5'b00001;
      r.lat = s / 4 + 2;
`endif
    end
    return r;
  endfunction

  task automatic compareResult(input exp_t e);
    checkOutput("sign",  {63'd0, out_sign}, {63'd0, e.sign});
    checkOutput("exp",   {51'd0, out_exp}, {51'd0, e.exp});
    checkOutput("mant",  {11'd0, out_mant}, {11'd0, e.mant});
    checkOutput("class", {59'd0, out_class}, {59'd0, e.cls});
    checkOutput("p",     {63'd0, out_p}, {63'd0, e.p});
  endtask

  // Drives one operand, waits for the result, optionally stalls out_ready while offering junk input.
  task automatic applyStimulus(input logic [63:0] op, input logic p, input int stall);
    exp_t e;
    int   edges;
    @(negedge clk);
    in_op    = op;
    in_p     = p;
    in_valid = 1'b1;
    sb.push_back(model(op, p));
    checkOutput("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = {$urandom, $urandom};
    edges    = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    e = sb.pop_front();
    checkOutput("latency", 64'(edges), 64'(e.lat));
    checkOutput("out_valid", {63'd0, out_valid}, 64'd1);
    compareResult(e);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_op    = 64'h3FF8000000000000;
      in_p     = ~p;
      @(posedge clk); #1;
      checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("hold_ready", {63'd0, in_ready}, 64'd0);
      compareResult(e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("drain_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("drain_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] op;
    logic        p;
    int          kind;
    exp_t        dummy;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_exp", {51'd0, out_exp}, 64'd0);
    checkOutput("rst_mant", {11'd0, out_mant}, 64'd0);
    checkOutput("rst_class", {59'd0, out_class}, 64'd0);
    checkOutput("rst_sign_p", {62'd0, out_sign, out_p}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);

    applyStimulus(64'h3FF0000000000000, 1'b0, 0);
    applyStimulus(64'h0000000000000001, 1'b0, 0);
    applyStimulus(64'hFF80000112345678, 1'b1, 0);
    applyStimulus(64'h7FC00000DEADBEEF, 1'b1, 0);
    applyStimulus(64'h8000000000000000, 1'b0, 0);
    applyStimulus(64'h7FF0000000000000, 1'b0, 0);
    applyStimulus(64'h7FF0000000000001, 1'b0, 0);
    applyStimulus(64'hFFF8000000000000, 1'b0, 0);
    applyStimulus(64'h00000001CAFEF00D, 1'b1, 0);
    applyStimulus(64'h0008000000000000, 1'b0, 0);
    applyStimulus(64'h8000000000100000, 1'b0, 0);
    applyStimulus(64'h80400000FFFFFFFF, 1'b1, 0);
    applyStimulus(64'hC0490FDB00000000, 1'b1, 5);
    applyStimulus(64'h000000000000000F, 1'b0, 3);

    // Reset asserted in the middle of a long denormal normalization.
    @(negedge clk);
    in_op    = 64'h0000000000000001;
    in_p     = 1'b0;
    in_valid = 1'b1;
    sb.push_back(model(in_op, in_p));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    dummy = sb.pop_front();
    checkOutput("abort_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("abort_exp", {51'd0, out_exp}, 64'd0);
    checkOutput("abort_mant", {11'd0, out_mant}, 64'd0);
    checkOutput("abort_class", {59'd0, out_class}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(64'h4009200000000000, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      op   = {$urandom, $urandom};
      p    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        if (p) op[62:55] = 8'd0; else op[62:52] = 11'd0;
      end else if (kind == 1) begin
        if (p) op[62:55] = 8'hFF; else op[62:52] = 11'h7FF;
      end
      applyStimulus(op, p, i % 3);
    end

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
